// File: rtl/game_state_pkg.sv
// Shared definitions for the Arkanoid game-phase controller: state encoding and sizing helper.
package game_state_pkg;

  // Encoding is shared with the renderers and the ball logic; keep the values stable.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_WIN   = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_state_rise_edge.sv
// Registered 0->1 detector; the previous-value register resets to RST_VAL so a level
// already high when reset is released does not produce an edge.
module game_state_rise_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise_c
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= RST_VAL;
    else        r_prev <= i_d;
  end

  assign o_rise_c = i_d & ~r_prev;

endmodule

// File: rtl/game_state.sv
// Game-phase controller: title/serve/play/game-over/victory sequencing, lives and brick
// bookkeeping, and the message/enable flags for the display and ball logic.
module game_state
  import game_state_pkg::*;
#(
  parameter int unsigned NUM_BRICKS   = 48,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_tick,
  input  logic                              start_btn,
  input  logic                              brick_hit,
  input  logic                              ball_lost,
  output logic                              init,
  output logic                              dead,
  output logic                              win,
  output logic                              playing,
  output logic                              serve,
  output logic [2:0]                        lives,
  output logic [$clog2(NUM_BRICKS+1)-1:0]   bricks_left
);

  localparam int unsigned BW   = $clog2(NUM_BRICKS + 1);
  localparam int unsigned FMAX = max_u(SERVE_FRAMES, HOLD_FRAMES);
  localparam int unsigned FW   = $clog2(FMAX + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_lives;
  logic [2:0]      w_lives_nxt;
  logic [BW-1:0]   r_bricks;
  logic [BW-1:0]   w_bricks_nxt;
  logic [FW-1:0]   r_frames;
  logic [FW-1:0]   w_frames_nxt;
  logic [FW-1:0]   w_frame_cap;
  logic            r_init;
  logic            r_dead;
  logic            r_win;
  logic            r_playing;
  logic            r_serve;
  logic            w_init_nxt;
  logic            w_dead_nxt;
  logic            w_win_nxt;
  logic            w_playing_nxt;
  logic            w_serve_nxt;
  logic            w_start;
  logic            w_hit;
  logic            w_lost;
  logic            w_hold_done;

  game_state_rise_edge #(
    .RST_VAL (1'b1)
  ) u_start_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_d      (start_btn),
    .o_rise_c (w_start)
  );

  // Counters never go below zero, so a pulse against an empty counter is dropped.
  assign w_hit       = brick_hit && (r_bricks != '0);
  assign w_lost      = ball_lost && (r_lives != '0);
  assign w_hold_done = (r_frames == FW'(HOLD_FRAMES));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // Next-state and counter next values.
  always_comb begin
    w_state_nxt  = r_state;
    w_lives_nxt  = r_lives;
    w_bricks_nxt = r_bricks;
    w_frame_cap  = FW'(SERVE_FRAMES);
    case (r_state)
      ST_INIT: begin
        if (w_start) w_state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (frame_tick && (r_frames == FW'(SERVE_FRAMES - 1))) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_hit) w_bricks_nxt = r_bricks - BW'(1);
        // Clearing the wall wins outright, even if the ball was lost in the same cycle.
        if (w_hit && (r_bricks == BW'(1))) begin
          w_state_nxt = ST_WIN;
        end else if (w_lost) begin
          w_lives_nxt = r_lives - 3'd1;
          w_state_nxt = (r_lives == 3'd1) ? ST_DEAD : ST_SERVE;
        end
      end
      ST_DEAD, ST_WIN: begin
        w_frame_cap = FW'(HOLD_FRAMES);
        if (w_start && w_hold_done) w_state_nxt = ST_INIT;
      end
      default: w_state_nxt = ST_INIT;
    endcase

    if ((r_state == ST_INIT) || (w_state_nxt == ST_INIT)) begin
      w_lives_nxt  = 3'(LIVES);
      w_bricks_nxt = BW'(NUM_BRICKS);
    end

    if (w_state_nxt != r_state)                    w_frames_nxt = '0;
    else if (frame_tick && (r_frames < w_frame_cap)) w_frames_nxt = r_frames + FW'(1);
    else                                           w_frames_nxt = r_frames;
  end

  // Output next values, decoded from the upcoming state so flags track it with no extra lag.
  always_comb begin
    w_init_nxt    = 1'b0;
    w_dead_nxt    = 1'b0;
    w_win_nxt     = 1'b0;
    w_playing_nxt = 1'b0;
    w_serve_nxt   = 1'b0;
    case (w_state_nxt)
      ST_INIT:  w_init_nxt    = 1'b1;
      ST_SERVE: w_serve_nxt   = (r_state != ST_SERVE);
      ST_PLAY:  w_playing_nxt = 1'b1;
      ST_DEAD:  w_dead_nxt    = 1'b1;
      ST_WIN:   w_win_nxt     = 1'b1;
      default:  w_init_nxt    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lives   <= 3'(LIVES);
      r_bricks  <= BW'(NUM_BRICKS);
      r_frames  <= '0;
      r_init    <= 1'b1;
      r_dead    <= 1'b0;
      r_win     <= 1'b0;
      r_playing <= 1'b0;
      r_serve   <= 1'b0;
    end else begin
      r_lives   <= w_lives_nxt;
      r_bricks  <= w_bricks_nxt;
      r_frames  <= w_frames_nxt;
      r_init    <= w_init_nxt;
      r_dead    <= w_dead_nxt;
      r_win     <= w_win_nxt;
      r_playing <= w_playing_nxt;
      r_serve   <= w_serve_nxt;
    end
  end

  assign init        = r_init;
  assign dead        = r_dead;
  assign win         = r_win;
  assign playing     = r_playing;
  assign serve       = r_serve;
  assign lives       = r_lives;
  assign bricks_left = r_bricks;

endmodule

// File: tb/tb_game_state.sv
// Directed bench for game_state: expected output vectors are queued as stimulus is
// driven and popped/compared once the outputs settle after the clock edge.
module tb_game_state;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       brick_hit = 1'b0;
  logic       ball_lost = 1'b0;
  logic       init, dead, win, playing, serve;
  logic [2:0] lives;
  logic [5:0] bricks_left;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  game_state #(
    .NUM_BRICKS   (48),
    .LIVES        (3),
    .SERVE_FRAMES (60),
    .HOLD_FRAMES  (120)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .brick_hit   (brick_hit),
    .ball_lost   (ball_lost),
    .init        (init),
    .dead        (dead),
    .win         (win),
    .playing     (playing),
    .serve       (serve),
    .lives       (lives),
    .bricks_left (bricks_left)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Vector layout: {init, dead, win, playing, serve, lives[2:0], bricks_left[5:0]}
  function automatic logic [13:0] ev(input logic i, input logic d, input logic w,
                                     input logic p, input logic s,
                                     input logic [2:0] l, input logic [5:0] b);
    return {i, d, w, p, s, l, b};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [13:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [13:0] obs;
    obs = {init, dead, win, playing, serve, lives, bricks_left};
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %h required an expected entry", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        n_errors++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step_check(input string tag, input logic [13:0] v);
    sb_push(tag, v);
    cyc();
    sb_check();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    // Reset with start held: must stay on the title screen afterwards.
    rst_n = 1'b0;
    start_btn = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    step_check("reset_held_start", ev(1, 0, 0, 0, 0, 3'd3, 6'd48));

    start_btn = 1'b0;
    cyc();
    start_btn = 1'b1;
    step_check("serve_entry", ev(0, 0, 0, 0, 1, 3'd3, 6'd48));
    step_check("serve_pulse_end", ev(0, 0, 0, 0, 0, 3'd3, 6'd48));
    start_btn = 1'b0;

    frames(59);
    sb_push("serve_59_frames", ev(0, 0, 0, 0, 0, 3'd3, 6'd48));
    sb_check();
    frame_tick = 1'b1;
    step_check("play_after_60", ev(0, 0, 0, 1, 0, 3'd3, 6'd48));
    frame_tick = 1'b0;

    // Lose all three lives.
    ball_lost = 1'b1;
    step_check("lost_1", ev(0, 0, 0, 0, 1, 3'd2, 6'd48));
    ball_lost = 1'b0;
    frames(60);
    sb_push("replay_1", ev(0, 0, 0, 1, 0, 3'd2, 6'd48));
    sb_check();
    ball_lost = 1'b1;
    step_check("lost_2", ev(0, 0, 0, 0, 1, 3'd1, 6'd48));
    ball_lost = 1'b0;
    frames(60);
    sb_push("replay_2", ev(0, 0, 0, 1, 0, 3'd1, 6'd48));
    sb_check();
    ball_lost = 1'b1;
    step_check("lost_3_dead", ev(0, 1, 0, 0, 0, 3'd0, 6'd48));
    ball_lost = 1'b0;

    // Early restart ignored and not remembered.
    frames(50);
    start_btn = 1'b1;
    step_check("dead_early_start", ev(0, 1, 0, 0, 0, 3'd0, 6'd48));
    start_btn = 1'b0;
    cyc();
    frames(70);
    step_check("dead_no_memory", ev(0, 1, 0, 0, 0, 3'd0, 6'd48));
    start_btn = 1'b1;
    step_check("dead_restart", ev(1, 0, 0, 0, 0, 3'd3, 6'd48));
    start_btn = 1'b0;
    cyc();

    // Second game: clear the wall.
    start_btn = 1'b1;
    step_check("serve_entry_2", ev(0, 0, 0, 0, 1, 3'd3, 6'd48));
    brick_hit = 1'b1;
    step_check("hit_ignored_serve", ev(0, 0, 0, 0, 0, 3'd3, 6'd48));
    brick_hit = 1'b0;
    start_btn = 1'b0;
    frames(60);
    sb_push("play_2", ev(0, 0, 0, 1, 0, 3'd3, 6'd48));
    sb_check();
    for (int k = 1; k <= 10; k++) begin
      brick_hit = 1'b1;
      step_check("brick_dec_a", ev(0, 0, 0, 1, 0, 3'd3, 6'(48 - k)));
      brick_hit = 1'b0;
    end
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step_check("hit_and_lost", ev(0, 0, 0, 0, 1, 3'd2, 6'd37));
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    frames(60);
    sb_push("play_3", ev(0, 0, 0, 1, 0, 3'd2, 6'd37));
    sb_check();
    for (int k = 1; k <= 36; k++) begin
      brick_hit = 1'b1;
      step_check("brick_dec_b", ev(0, 0, 0, 1, 0, 3'd2, 6'(37 - k)));
      brick_hit = 1'b0;
    end
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step_check("last_brick_win", ev(0, 0, 1, 0, 0, 3'd2, 6'd0));
    brick_hit = 1'b0;
    ball_lost = 1'b0;

    // Hold counter saturates; restart after the hold.
    frames(125);
    step_check("win_hold", ev(0, 0, 1, 0, 0, 3'd2, 6'd0));
    start_btn = 1'b1;
    step_check("win_restart", ev(1, 0, 0, 0, 0, 3'd3, 6'd48));
    start_btn = 1'b0;
    cyc();

    // Reset in the middle of play with a pending hit.
    start_btn = 1'b1;
    step_check("serve_entry_3", ev(0, 0, 0, 0, 1, 3'd3, 6'd48));
    frames(60);
    brick_hit = 1'b1;
    step_check("play_hit", ev(0, 0, 0, 1, 0, 3'd3, 6'd47));
    rst_n = 1'b0;
    step_check("reset_mid_play", ev(1, 0, 0, 0, 0, 3'd3, 6'd48));
    rst_n = 1'b1;
    brick_hit = 1'b0;
    step_check("after_reset_held", ev(1, 0, 0, 0, 0, 3'd3, 6'd48));
    start_btn = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_state.md
# game_state

Top-level game-phase controller for the Arkanoid display path. It tracks title, serve, play, game-over and victory phases, lives and remaining bricks. It drives the `init`/`dead`/`win` message flags consumed by the background/message renderer and a `playing` enable consumed by the ball/paddle logic. Time-based behaviour is counted in frames via a one-cycle `frame_tick` from the VGA timing block.

## Interface
Parameters:
- `NUM_BRICKS`, 48 — bricks in a full wall; reload value of the brick counter.
- `LIVES`, 3 — lives at game start; 1..7.
- `SERVE_FRAMES`, 60 — frames the ball is held before play resumes.
- `HOLD_FRAMES`, 120 — minimum frames a DEAD/WIN message stays before restart is accepted.

Ports:
- `clk` in 1 — system clock; one clock domain.
- `rst_n` in 1 — reset, synchronous, active-low.
- `frame_tick` in 1 — one-cycle pulse per frame (start of vertical blank).
- `start_btn` in 1 — debounced level button; action on 0→1 edge only.
- `brick_hit` in 1 — one-cycle pulse per destroyed brick.
- `ball_lost` in 1 — one-cycle pulse when the ball passes the paddle.
- `init` out 1 — title message active.
- `dead` out 1 — game-over message active.
- `win` out 1 — victory message active.
- `playing` out 1 — ball motion enabled.
- `serve` out 1 — one-cycle pulse; ball/paddle return to serve position.
- `lives` out 3 — lives remaining.
- `bricks_left` out `$clog2(NUM_BRICKS+1)` — bricks remaining.

## Operation
- States: INIT, SERVE, PLAY, DEAD, WIN.
- INIT: `init`=1. On a start edge → SERVE. Reload `lives`=LIVES and `bricks_left`=NUM_BRICKS.
- SERVE: all message flags 0, `playing`=0. `serve` pulses in the first cycle of the state. The frame counter counts `frame_tick`. When the count reaches SERVE_FRAMES → PLAY.
- PLAY: `playing`=1.
  - `brick_hit` decrements `bricks_left`. If that decrement reaches 0 → WIN.
  - `ball_lost` decrements `lives`. If that decrement reaches 0 → DEAD; otherwise → SERVE.
- DEAD / WIN: `dead`=1 or `win`=1 respectively. The frame counter counts up to HOLD_FRAMES and saturates there. A start edge is accepted only once the counter has reached HOLD_FRAMES; it then → INIT. An earlier edge is ignored and is not remembered.
- Exactly one of `init`/`dead`/`win` is 1 in INIT/DEAD/WIN. All three are 0 in SERVE/PLAY. `playing` is 1 only in PLAY.
- `brick_hit` and `ball_lost` are ignored outside PLAY.
- Simultaneous `brick_hit` and `ball_lost` in PLAY: the brick is counted. If it was the last brick → WIN, and `lives` is unchanged. Otherwise both counters decrement and the lives rule applies.
- Counters never wrap: no decrement below 0.
- Start edge detector: the previous-value register resets to 1, so a button held through reset does not start a game.
- The frame counter clears on every state entry and is sized to cover max(SERVE_FRAMES, HOLD_FRAMES).

## Timing
- Reset values: `init`=1, `dead`=0, `win`=0, `playing`=0, `serve`=0, `lives`=LIVES, `bricks_left`=NUM_BRICKS, state INIT.
- All outputs are registered. An event sampled at edge N is reflected in the outputs after edge N (1-cycle latency).
- `serve` is high for exactly the first cycle in which the state is SERVE.
- SERVE→PLAY occurs in the cycle after the SERVE_FRAMES-th `frame_tick` seen in SERVE.
- `rst_n` low mid-game forces the reset values at the next edge, regardless of state or pending events.

## Structure
- Shared `def.v` holds the state encoding localparams (ST_INIT, ST_SERVE, ST_PLAY, ST_DEAD, ST_WIN) so the renderers and the ball logic decode the same values.
- One natural sub-module: `rise_edge`, a registered 0→1 detector with a reset value parameter, used for `start_btn`.

## Test plan
- Reset with `start_btn` held at 1 → stays INIT, `init`=1. Release and press → one cycle later SERVE with `serve`=1 for 1 cycle. After 60 `frame_tick` → `playing`=1.
- PLAY with `ball_lost` pulsed 3 times, each followed by SERVE timeout → `lives` goes 2, 1, 0. After the third pulse: DEAD, `dead`=1, `playing`=0.
- 48 `brick_hit` pulses in PLAY → `bricks_left` goes 47…0. The cycle after the 48th: WIN, `win`=1.
- `bricks_left`=1 with `brick_hit` and `ball_lost` in the same cycle → WIN, `lives` unchanged.
- In DEAD, start edge at frame 50 → ignored. Start edge after 120 frames → INIT, `lives`=3, `bricks_left`=48.
- `rst_n` low for 1 cycle during PLAY with `brick_hit` asserted → INIT, all reset values, `bricks_left`=48.
